// File: rtl/regfile_memory_pkg.sv
// Shared sizing and index constants for the integer register file.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Contents: default DATA_WIDTH / ADDR_WIDTH, REG_COUNT, the hard-wired
// zero register index, word/address typedefs and a small write-qualify helper.
package regfile_memory_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int REG_COUNT  = 2 ** ADDR_WIDTH;

    // Index of the register that always reads zero and ignores writes.
    localparam int ZERO_REG = 0;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    // A write only lands when it is strobed and does not target register 0.
    function automatic logic write_qualified(input logic wr_enable,
                                             input logic is_zero_reg);
        return wr_enable && !is_zero_reg;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file: array lookup, zero-register forcing, optional write bypass.
// Latency: 0 cycles, address to data is purely combinational.
// Backpressure: none, a read can be issued every cycle on every port.
//
// Ports:
//   mem           - storage array from the top level
//   rst           - reset level (suppresses the bypass while high)
//   rd_address    - register index to read
//   wr_enable / wr_address / wr_data - current write-port request, used by the bypass
//   data_out      - register contents (or bypassed write data)
//
// Configuration: REGFILE_WRITE_BYPASS_EN defined forwards a pending write to a
// matching read before the falling edge commits it; undefined reads storage only.
module regfile_read_port
    import regfile_memory_pkg::*;
#(
    parameter int DATA_WIDTH = regfile_memory_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_memory_pkg::ADDR_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH],
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    input  logic                  wr_enable,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic rd_is_zero;

    assign rd_is_zero = (rd_address == ADDR_WIDTH'(ZERO_REG));

`ifdef REGFILE_WRITE_BYPASS_EN
    logic bypass_hit;

    // Forward only a write that will actually commit on the coming edge:
    // strobed, not to register 0, same index, and not cancelled by reset.
    assign bypass_hit = write_qualified(wr_enable, wr_address == ADDR_WIDTH'(ZERO_REG))
                        && !rst
                        && (wr_address == rd_address);

    always_comb begin
        data_out = mem[rd_address];
        if (bypass_hit) begin
            data_out = wr_data;
        end
        // Zero forcing wins over everything, including the bypass.
        if (rd_is_zero) begin
            data_out = '0;
        end
    end
`else
    // Write-port signals only feed the bypass; fold them away here.
    logic unused_bypass;
    assign unused_bypass = ^{rst, wr_enable, wr_address, wr_data};

    always_comb begin
        data_out = mem[rd_address];
        if (rd_is_zero) begin
            data_out = '0;
        end
    end
`endif

endmodule

// File: rtl/regfile_memory.sv
// Integer register file: 2**ADDR_WIDTH x DATA_WIDTH, two combinational read ports, one falling-edge write port, register 0 reads zero.
// Latency: reads 0 cycles; writes visible right after the falling edge that commits them.
// Backpressure: none, one write and two reads accepted every cycle.
//
// Ports:
//   clk                         - clock; writes and reset act on the falling edge
//   rst                         - synchronous active-high reset, clears every word
//   rd_address_a / data_out_a   - read port A (rs1)
//   rd_address_b / data_out_b   - read port B (rs2)
//   wr_enable / wr_address / wr_data - write port (rd from write-back)
//
// Configuration: define REGFILE_WRITE_BYPASS_EN to forward a pending write to
// matching read ports before the edge; default build leaves it undefined.
module regfile_memory
    import regfile_memory_pkg::*;
#(
    parameter int DATA_WIDTH = regfile_memory_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_memory_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rd_address_a,
    input  logic [ADDR_WIDTH-1:0] rd_address_b,
    input  logic                  wr_enable,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] data_out_a,
    output logic [DATA_WIDTH-1:0] data_out_b
);

    localparam int WORDS = 2 ** ADDR_WIDTH;

    // Power-up contents are zero so reads are defined before the first reset.
    logic [DATA_WIDTH-1:0] mem [WORDS] = '{default: '0};

    logic wr_commit;

    assign wr_commit = write_qualified(wr_enable, wr_address == ADDR_WIDTH'(ZERO_REG));

    // Falling-edge update so write-back in the first half of a cycle is
    // readable by decode in the second half. Reset beats a coincident write.
    always_ff @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_commit) begin
            mem[wr_address] <= wr_data;
        end
    end

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_port_a (
        .mem        (mem),
        .rst        (rst),
        .rd_address (rd_address_a),
        .wr_enable  (wr_enable),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .data_out   (data_out_a)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_port_b (
        .mem        (mem),
        .rst        (rst),
        .rd_address (rd_address_b),
        .wr_enable  (wr_enable),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .data_out   (data_out_b)
    );

endmodule

// File: tb/tb_regfile_memory.sv
// Directed bench for regfile_memory: power-up, write/read, zero register, reset, bypass and edge behaviour.
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_memory;
    import regfile_memory_pkg::*;

    logic  clk;
    logic  rst;
    addr_t rd_address_a;
    addr_t rd_address_b;
    logic  wr_enable;
    addr_t wr_address;
    word_t wr_data;
    word_t data_out_a;
    word_t data_out_b;

    int checks = 0;
    int errors = 0;

    regfile_memory dut (
        .clk          (clk),
        .rst          (rst),
        .rd_address_a (rd_address_a),
        .rd_address_b (rd_address_b),
        .wr_enable    (wr_enable),
        .wr_address   (wr_address),
        .wr_data      (wr_data),
        .data_out_a   (data_out_a),
        .data_out_b   (data_out_b)
    );

    // clk starts high: falling edges at 5, 15, 25 ... rising edges at 10, 20 ...
    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Drive a write request and let one falling edge commit it.
    task automatic do_write(input addr_t a, input word_t d);
        @(posedge clk); #1;
        wr_enable  = 1'b1;
        wr_address = a;
        wr_data    = d;
        @(negedge clk); #1;
        wr_enable  = 1'b0;
    endtask

    task automatic test_power_up;
        rd_address_a = 5'h00;
        rd_address_b = 5'h0A;
        #1;
        checks++;
        if (data_out_a !== 32'h0000_0000) begin
            errors++; $display("FAIL power_up_a: got %h expected %h", data_out_a, 32'h0);
        end
        checks++;
        if (data_out_b !== 32'h0000_0000) begin
            errors++; $display("FAIL power_up_b: got %h expected %h", data_out_b, 32'h0);
        end
    endtask

    task automatic test_write_read;
        do_write(5'h0A, 32'hABCD_EFAB);
        rd_address_b = 5'h0A;
        #1;
        checks++;
        if (data_out_b !== 32'hABCD_EFAB) begin
            errors++; $display("FAIL write_read_b: got %h expected %h", data_out_b, 32'hABCDEFAB);
        end
        rd_address_a = 5'h0A;
        #1;
        checks++;
        if (data_out_a !== 32'hABCD_EFAB) begin
            errors++; $display("FAIL write_read_a: got %h expected %h", data_out_a, 32'hABCDEFAB);
        end
        checks++;
        if (data_out_b !== 32'hABCD_EFAB) begin
            errors++; $display("FAIL write_read_b_hold: got %h expected %h", data_out_b, 32'hABCDEFAB);
        end
    endtask

    task automatic test_zero_reg;
        @(negedge clk); #1;
        wr_enable    = 1'b1;
        wr_address   = 5'h00;
        wr_data      = 32'hEEEE_EEEE;
        rd_address_a = 5'h00;
        rd_address_b = 5'h00;
        @(posedge clk); #1;
        @(negedge clk); #1;
        wr_enable = 1'b0;
        checks++;
        if (data_out_a !== 32'h0000_0000) begin
            errors++; $display("FAIL zero_reg_a: got %h expected %h", data_out_a, 32'h0);
        end
        checks++;
        if (data_out_b !== 32'h0000_0000) begin
            errors++; $display("FAIL zero_reg_b: got %h expected %h", data_out_b, 32'h0);
        end
    endtask

    task automatic test_reset;
        do_write(5'h1F, 32'h1234_5678);
        rd_address_a = 5'h1F;
        rd_address_b = 5'h0A;
        #1;
        checks++;
        if (data_out_a !== 32'h1234_5678) begin
            errors++; $display("FAIL reset_pre_1f: got %h expected %h", data_out_a, 32'h12345678);
        end
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        checks++;
        if (data_out_a !== 32'h0000_0000) begin
            errors++; $display("FAIL reset_clear_1f: got %h expected %h", data_out_a, 32'h0);
        end
        checks++;
        if (data_out_b !== 32'h0000_0000) begin
            errors++; $display("FAIL reset_clear_0a: got %h expected %h", data_out_b, 32'h0);
        end
        // Reset and a write on the same edge: reset wins.
        @(posedge clk); #1;
        rst        = 1'b1;
        wr_enable  = 1'b1;
        wr_address = 5'h05;
        wr_data    = 32'h5555_AAAA;
        rd_address_a = 5'h05;
        @(negedge clk); #1;
        rst       = 1'b0;
        wr_enable = 1'b0;
        checks++;
        if (data_out_a !== 32'h0000_0000) begin
            errors++; $display("FAIL reset_priority_05: got %h expected %h", data_out_a, 32'h0);
        end
        // Writes resume on the first edge with rst low.
        do_write(5'h05, 32'h0BAD_BEEF);
        checks++;
        if (data_out_a !== 32'h0BAD_BEEF) begin
            errors++; $display("FAIL reset_resume_05: got %h expected %h", data_out_a, 32'h0BADBEEF);
        end
    endtask

    task automatic test_bypass;
        word_t exp_pre;
        do_write(5'h03, 32'h1111_1111);
`ifdef REGFILE_WRITE_BYPASS_EN
        exp_pre = 32'hCAFE_F00D;
`else
        exp_pre = 32'h1111_1111;
`endif
        @(posedge clk); #1;
        wr_enable    = 1'b1;
        wr_address   = 5'h03;
        wr_data      = 32'hCAFE_F00D;
        rd_address_a = 5'h03;
        rd_address_b = 5'h03;
        #1;
        checks++;
        if (data_out_a !== exp_pre) begin
            errors++; $display("FAIL bypass_pre_a: got %h expected %h", data_out_a, exp_pre);
        end
        checks++;
        if (data_out_b !== exp_pre) begin
            errors++; $display("FAIL bypass_pre_b: got %h expected %h", data_out_b, exp_pre);
        end
        @(negedge clk); #1;
        wr_enable = 1'b0;
        checks++;
        if (data_out_a !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL bypass_post_a: got %h expected %h", data_out_a, 32'hCAFEF00D);
        end
        // Reset high suppresses forwarding: old stored value shows before the edge.
        @(posedge clk); #1;
        rst        = 1'b1;
        wr_enable  = 1'b1;
        wr_address = 5'h03;
        wr_data    = 32'h7777_7777;
        #1;
        checks++;
        if (data_out_a !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL bypass_rst_suppress: got %h expected %h", data_out_a, 32'hCAFEF00D);
        end
        @(negedge clk); #1;
        rst       = 1'b0;
        wr_enable = 1'b0;
        checks++;
        if (data_out_a !== 32'h0000_0000) begin
            errors++; $display("FAIL bypass_rst_clear: got %h expected %h", data_out_a, 32'h0);
        end
    endtask

    task automatic test_rising_edge;
        word_t exp_mid;
        do_write(5'h07, 32'h0000_00AA);
`ifdef REGFILE_WRITE_BYPASS_EN
        exp_mid = 32'h0000_00BB;
`else
        exp_mid = 32'h0000_00AA;
`endif
        // Present the new write just after a falling edge so a rising edge passes first.
        @(negedge clk); #1;
        wr_enable    = 1'b1;
        wr_address   = 5'h07;
        wr_data      = 32'h0000_00BB;
        rd_address_b = 5'h07;
        @(posedge clk); #1;
        checks++;
        if (data_out_b !== exp_mid) begin
            errors++; $display("FAIL rising_no_commit: got %h expected %h", data_out_b, exp_mid);
        end
        @(negedge clk); #1;
        wr_enable = 1'b0;
        checks++;
        if (data_out_b !== 32'h0000_00BB) begin
            errors++; $display("FAIL rising_then_fall: got %h expected %h", data_out_b, 32'h000000BB);
        end
    endtask

    initial begin
        rst          = 1'b0;
        rd_address_a = '0;
        rd_address_b = '0;
        wr_enable    = 1'b0;
        wr_address   = '0;
        wr_data      = '0;
        test_power_up();
        test_write_read();
        test_zero_reg();
        test_reset();
        test_bypass();
        test_rising_edge();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_memory.md
# regfile_memory

Integer register file for the processor core: 32 general-purpose registers of 32 bits, two combinational read ports and one write port. Register 0 is hard-wired to zero. The decode stage reads rs1/rs2 through ports A/B and write-back writes rd through the single write port. Writes commit on the falling clock edge, so a value written in the first half of a cycle is readable in the second half.

## Interface

One clock; reset is synchronous and active-high.

Parameters:
- DATA_WIDTH, 32: register width in bits.
- ADDR_WIDTH, 5: register index width; register count is 2**ADDR_WIDTH.

Ports:
- clk, input, 1: clock; writes and reset act on the falling edge.
- rst, input, 1: synchronous active-high reset.
- rd_address_a, input, ADDR_WIDTH: read port A index.
- rd_address_b, input, ADDR_WIDTH: read port B index.
- wr_enable, input, 1: write strobe.
- wr_address, input, ADDR_WIDTH: write index.
- wr_data, input, DATA_WIDTH: write data.
- data_out_a, output, DATA_WIDTH: contents of register rd_address_a.
- data_out_b, output, DATA_WIDTH: contents of register rd_address_b.

## Operation

- Storage is 2**ADDR_WIDTH words of DATA_WIDTH bits. Every word initialises to 0 at simulation start, so outputs read 0 before any reset or write.
- Reads are purely combinational. data_out_x equals the stored word at rd_address_x, with no clock involvement.
- Reading index 0 always returns 0, regardless of write history.
- Write: on the falling edge of clk, if wr_enable=1 and wr_address≠0, then mem[wr_address] ← wr_data.
- A write to index 0 is silently discarded and raises no error.
- Reset: on the falling edge of clk with rst=1, all words clear to 0. Reset has priority over a simultaneous write.
- Both ports may address the same register, including the one being written. Both ports must return identical data.

## Timing

- Read latency is 0 cycles, combinational from address to data. An address change propagates within the same delta or timestep.
- Write latency: new data appears on any read port addressing wr_address immediately after the falling edge that commits it.
- Before that edge, a read returns the old value unless the bypass option is enabled (see Configuration).
- Rising edges have no effect.
- Output reset values: 0 on both ports for any address once reset has been applied.
- Reset applied mid-operation discards the write pending on that edge. Writes resume on the first falling edge with rst=0.
- wr_enable, wr_address and wr_data need only be stable around the falling edge.

## Configuration

- REGFILE_WRITE_BYPASS_EN defined: while wr_enable=1 and wr_address≠0, a read port whose address equals wr_address outputs wr_data combinationally, before the edge.
- Index 0 still reads 0.
- rst=1 suppresses the bypass.
- REGFILE_WRITE_BYPASS_EN undefined: reads always reflect stored contents only.
- Default build leaves REGFILE_WRITE_BYPASS_EN undefined.

## Structure

- Package regfile_memory_pkg: DATA_WIDTH and ADDR_WIDTH defaults, REG_COUNT, ZERO_REG index constant (0), and word/address typedefs.
- Sub-module regfile_read_port, instantiated twice (A, B). It implements the index-0 forcing and the optional bypass mux from the storage array, address and write-port signals.
- The top level holds the storage array, the falling-edge write/reset process and the two port instances.

## Test plan

- No reset, no writes: rd_address_a=0, rd_address_b=0x0A → data_out_a=0x00000000, data_out_b=0x00000000.
- Write 0x0A ← 0xABCDEFAB (wr_enable=1), falling edge, then wr_enable=0 with rd_address_b=0x0A → data_out_b=0xABCDEFAB with no further clock edge.
- Then set rd_address_a=0x0A → data_out_a=0xABCDEFAB, and data_out_b still reads 0xABCDEFAB.
- Write 0x00 ← 0xEEEEEEEE with wr_enable=1 across a rising then falling edge; both ports at index 0 → both read 0x00000000.
- Write 0x1F ← 0x12345678, then assert rst=1 for one falling edge → index 0x1F reads 0. Drive rst=1 and a write to 0x05 on the same edge → index 0x05 reads 0.
- Present a write to 0x03 ← 0xCAFEF00D with rd_address_a=0x03 before the falling edge:
  - REGFILE_WRITE_BYPASS_EN defined: data_out_a=0xCAFEF00D before the edge.
  - REGFILE_WRITE_BYPASS_EN undefined: data_out_a shows the old value before the edge.
  - Either build: data_out_a=0xCAFEF00D after the edge.
